uart_tx_hex_seq: RTL and testbench
==================================

# uart_tx_hex_seq

Byte-to-ASCII-hex transmit sequencer that sits in front of `uart_tx` and owns its `start`/`din`/`done` handshake. Each accepted byte is sent as two upper-case ASCII hex characters, high nibble first, with an optional CR LF appended. A one-entry input buffer accepts the next byte while the current frame is being sent. A watchdog abandons any character whose `done` never arrives.

## Interface
- `TO_BIT`, default 16: width of the watchdog counter.
- `TO_MAX`, default 16'hFFFF: number of WAIT cycles without `tx_done` before timeout. At 50 MHz and 9600 baud this exceeds one 12-bit-period character (62496 cycles).

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `n_rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` is offered.
- `in_data`  in  8: byte to transmit.
- `in_ready`  out  1: buffer empty, so a byte can be accepted. Equals `!buf_full`.
- `crlf_en`  in  1: append 8'h0D, 8'h0A to the frame. Sampled in LOAD.
- `err_clr`  in  1: clears `err_timeout`.
- `tx_start`  out  1: one-cycle start pulse to `uart_tx.start`.
- `tx_din`  out  8: character to `uart_tx.din`. Held stable from START until `tx_done`.
- `tx_done`  in  1: one-cycle done pulse from `uart_tx.done`.
- `busy`  out  1: high in every state except IDLE.
- `err_timeout`  out  1: sticky watchdog flag.

## Operation
- Input buffer: a byte is accepted on an edge where `in_valid && in_ready`; that edge sets `buf_full`. LOAD clears `buf_full`. Accept and drain cannot happen on the same edge, because `in_ready` is low while the buffer is full.
- Hex map: nibble 0–9 -> 8'h30 + n; nibble 10–15 -> 8'h37 + n (A = 8'h41). Result is 8-bit with no overflow.
- Frame: char0 = hex(byte[7:4]), char1 = hex(byte[3:0]), char2 = 8'h0D, char3 = 8'h0A. Last index is 1 if `crlf_en` was 0 at LOAD, otherwise 3.
- State machine (registered 2-bit character index `idx`):
  - IDLE: if `buf_full`, go to LOAD.
  - LOAD: copy the buffer into the work register, latch `crlf_en`, set `idx` = 0, clear the buffer, go to START.
  - START: `tx_start` = 1 and `tx_din` = char[idx] for exactly this cycle. Clear the watchdog. Go to WAIT.
  - WAIT: `tx_start` = 0; `tx_din` holds. The watchdog increments each cycle.
    - On `tx_done`: if `idx` == last, go to IDLE; otherwise `idx`++ and go to START.
    - If the watchdog reaches `TO_MAX` without `tx_done`: set `err_timeout`, drop the rest of the frame, go to IDLE.
- `tx_done` is ignored outside WAIT.
- `err_timeout`: the set condition wins over a simultaneous `err_clr`. Otherwise `err_clr` clears it on the next edge. The flag does not block new frames.
- `baudrate` is not handled here; it is wired to `uart_tx` at the top level.

## Timing
- Reset values: state IDLE, `buf_full` 0 (so `in_ready` 1), `tx_start` 0, `tx_din` 8'h00, `busy` 0, `err_timeout` 0, `idx` 0, watchdog 0.
- Latency: accept edge E -> LOAD in cycle E+1 -> `tx_start` high in cycle E+2.
- Character gap: a `tx_done` in cycle C gives `tx_start` in cycle C+1, with `tx_din` updated in that same cycle.
- Frame end: last `tx_done` in cycle C -> IDLE in C+1. If the buffer is full, LOAD in C+2 and next `tx_start` in C+3.
- `in_ready` falls on the edge after an accept and rises on the edge after LOAD.
- Timeout: if no `tx_done` arrives, `err_timeout` rises `TO_MAX` cycles after START, with `busy` falling on the same edge.
- Reset mid-frame: all registers return to reset values immediately. The buffered byte and the current frame are lost. `uart_tx` shares `n_rst` and aborts too.

## Test plan
- 8'h3A, `crlf_en` = 0 -> exactly two `tx_start` pulses with `tx_din` 8'h33 then 8'h41. `busy` falls one cycle after the second `tx_done`.
- 8'hF0, `crlf_en` = 1 -> `tx_din` sequence 8'h46, 8'h30, 8'h0D, 8'h0A. Each `tx_start` comes one cycle after the previous `tx_done`. `tx_din` is stable through every WAIT.
- Drive `in_valid` continuously with 8'h09, 8'h9F, 8'hFF -> `in_ready` toggles per buffer rule, the output is "09", "9F", "FF" in order, and no byte is lost or duplicated. Use real `uart_tx` with the SIM divisors.
- `TO_MAX` = 20, `tx_done` tied 0, byte 8'h55 -> one `tx_start` with 8'h35, then `err_timeout` = 1 and `busy` = 0, 20 cycles after START. A following byte 8'h12 still sends 8'h31, 8'h32. Asserting `err_clr` clears the flag.
- Pulse `tx_done` in IDLE and in START -> no state change, no extra `tx_start`.
- Assert `n_rst` low during the WAIT for char1 with the buffer full -> all outputs return to reset values. After release, `in_ready` = 1 and no `tx_start` occurs until a new byte is accepted.

Source files
------------

// File: rtl/uart_tx_hex_seq_if.sv
// Byte-in / character-out handshake bundle for the hex transmit sequencer.
// The master side is the byte producer plus the uart_tx done return; the slave is the sequencer.
interface uart_tx_hex_seq_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       crlf_en;
   logic       err_clr;
   logic       tx_start;
   logic [7:0] tx_din;
   logic       tx_done;
   logic       busy;
   logic       err_timeout;

   modport master (
      output in_valid, in_data, crlf_en, err_clr, tx_done,
      input  in_ready, tx_start, tx_din, busy, err_timeout
   );

   modport slave (
      input  in_valid, in_data, crlf_en, err_clr, tx_done,
      output in_ready, tx_start, tx_din, busy, err_timeout
   );
endinterface

// File: rtl/uart_tx_hex_seq.sv
// Byte-to-ASCII-hex transmit sequencer in front of uart_tx: two hex characters per byte,
// optional CR LF, one-entry input buffer and a per-character done watchdog.
module uart_tx_hex_seq #(
   parameter int unsigned       TO_BIT = 16,
   parameter logic [TO_BIT-1:0] TO_MAX = 16'hFFFF
) (
   input logic              clk,
   input logic              n_rst,
   uart_tx_hex_seq_if.slave bus
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 2;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_e;

   state_e              state_q, state_d;
   logic                buf_full_q, buf_full_d;
   logic [BYTE_W-1:0]   buf_q, buf_d;
   logic [BYTE_W-1:0]   work_q, work_d;
   logic                crlf_q, crlf_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [TO_BIT-1:0]   wd_q, wd_d;
   logic                tx_start_q, tx_start_d;
   logic [BYTE_W-1:0]   tx_din_q, tx_din_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [IDX_W-1:0]    last_idx_c;
   logic [TO_BIT-1:0]   wd_inc_c;

   function automatic logic [BYTE_W-1:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + BYTE_W'(n)) : (8'h37 + BYTE_W'(n));
   endfunction

   function automatic logic [BYTE_W-1:0] frame_char(input logic [BYTE_W-1:0] b,
                                                    input logic [IDX_W-1:0]  i);
      logic [BYTE_W-1:0] c;
      case (i)
         2'd0:    c = hex_char(b[7:4]);
         2'd1:    c = hex_char(b[3:0]);
         2'd2:    c = 8'h0D;
         default: c = 8'h0A;
      endcase
      return c;
   endfunction

   assign last_idx_c = crlf_q ? 2'd3 : 2'd1;
   assign wd_inc_c   = wd_q + TO_BIT'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      buf_full_d = buf_full_q;
      buf_d      = buf_q;
      work_d     = work_q;
      crlf_d     = crlf_q;
      idx_d      = idx_q;
      wd_d       = wd_q;
      tx_start_d = 1'b0;
      tx_din_d   = tx_din_q;
      err_d      = bus.err_clr ? 1'b0 : err_q;

      if (bus.in_valid && !buf_full_q) begin
         buf_full_d = 1'b1;
         buf_d      = bus.in_data;
      end

      case (state_q)
         S_IDLE: begin
            if (buf_full_q) state_d = S_LOAD;
         end
         S_LOAD: begin
            work_d     = buf_q;
            crlf_d     = bus.crlf_en;
            idx_d      = '0;
            buf_full_d = 1'b0;
            tx_start_d = 1'b1;
            tx_din_d   = frame_char(buf_q, 2'd0);
            state_d    = S_START;
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.tx_done) begin
               if (idx_q == last_idx_c) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d      = idx_q + 2'd1;
                  tx_start_d = 1'b1;
                  tx_din_d   = frame_char(work_q, idx_d);
                  state_d    = S_START;
               end
            // wd_q counts finished WAIT cycles; the START cycle is the first of TO_MAX
            end else if (wd_inc_c == TO_MAX - TO_BIT'(1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_inc_c;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         buf_full_q <= 1'b0;
         buf_q      <= '0;
         work_q     <= '0;
         crlf_q     <= 1'b0;
         idx_q      <= '0;
         wd_q       <= '0;
         tx_start_q <= 1'b0;
         tx_din_q   <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         buf_q      <= buf_d;
         work_q     <= work_d;
         crlf_q     <= crlf_d;
         idx_q      <= idx_d;
         wd_q       <= wd_d;
         tx_start_q <= tx_start_d;
         tx_din_q   <= tx_din_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready    = ~buf_full_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_din      = tx_din_q;
   assign bus.busy        = busy_q;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_hex_seq.sv
// Directed bench for uart_tx_hex_seq; the bench plays byte producer and uart_tx done responder.
module tb_uart_tx_hex_seq;

   logic clk;
   logic n_rst;
   int   checks;
   int   failures;

   uart_tx_hex_seq_if bus();

   uart_tx_hex_seq #(.TO_BIT(16), .TO_MAX(16'd20)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Send one frame with the bench answering each character after a growing WAIT.
   task automatic send_frame(input logic [7:0] b, input logic crlf, input int n,
                             input logic [31:0] exp, input string tag);
      logic [7:0] ch;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.crlf_en  = crlf;
      tick;
      bus.in_valid = 1'b0;
      chk({tag, "_ready_fall"}, 32'(bus.in_ready), 32'd0);
      tick;
      tick;
      bus.crlf_en = ~crlf;
      for (int i = 0; i < n; i++) begin
         ch = exp[31-8*i -: 8];
         chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
         chk({tag, "_din"}, 32'(bus.tx_din), 32'(ch));
         tick;
         for (int j = 0; j <= i; j++) begin
            chk({tag, "_wait_start"}, 32'(bus.tx_start), 32'd0);
            chk({tag, "_wait_din"}, 32'(bus.tx_din), 32'(ch));
            if (j < i) tick;
         end
         bus.tx_done = 1'b1;
         tick;
         bus.tx_done = 1'b0;
      end
      chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_end_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   // One-character frame whose done never comes.
   task automatic timeout_frame(input logic [7:0] b, input logic [7:0] c0, input string tag);
      int starts;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.crlf_en  = 1'b0;
      tick;
      bus.in_valid = 1'b0;
      tick;
      tick;
      chk({tag, "_start"}, 32'(bus.tx_start), 32'd1);
      chk({tag, "_din"}, 32'(bus.tx_din), 32'(c0));
      starts = 0;
      repeat (19) begin
         tick;
         starts += int'(bus.tx_start);
      end
      chk({tag, "_err_early"}, 32'(bus.err_timeout), 32'd0);
      chk({tag, "_busy_early"}, 32'(bus.busy), 32'd1);
      tick;
      starts += int'(bus.tx_start);
      chk({tag, "_err"}, 32'(bus.err_timeout), 32'd1);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_no_restart"}, 32'(starts), 32'd0);
   endtask

   initial begin
      logic [7:0] src [3];
      logic [7:0] exp3 [6];
      logic [7:0] got [6];
      int         si;
      int         n_out;
      int         cnt;
      int         starts;
      logic       acc;
      logic       fin;

      checks       = 0;
      failures     = 0;
      n_rst        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.crlf_en  = 1'b0;
      bus.err_clr  = 1'b0;
      bus.tx_done  = 1'b0;

      tick;
      tick;
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_start", 32'(bus.tx_start), 32'd0);
      chk("rst_din", 32'(bus.tx_din), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err_timeout), 32'd0);
      n_rst = 1'b1;
      tick;

      // 8'h3A, no CR LF: exact cycle-by-cycle latency
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h3A;
      tick;
      bus.in_valid = 1'b0;
      chk("t1_ready_fall", 32'(bus.in_ready), 32'd0);
      chk("t1_idle_busy", 32'(bus.busy), 32'd0);
      tick;
      chk("t1_load_busy", 32'(bus.busy), 32'd1);
      chk("t1_load_start", 32'(bus.tx_start), 32'd0);
      chk("t1_load_ready", 32'(bus.in_ready), 32'd0);
      tick;
      chk("t1_start0", 32'(bus.tx_start), 32'd1);
      chk("t1_din0", 32'(bus.tx_din), 32'h33);
      chk("t1_ready_rise", 32'(bus.in_ready), 32'd1);
      tick;
      chk("t1_wait0_start", 32'(bus.tx_start), 32'd0);
      chk("t1_wait0_din", 32'(bus.tx_din), 32'h33);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("t1_start1", 32'(bus.tx_start), 32'd1);
      chk("t1_din1", 32'(bus.tx_din), 32'h41);
      tick;
      chk("t1_wait1_start", 32'(bus.tx_start), 32'd0);
      chk("t1_wait1_busy", 32'(bus.busy), 32'd1);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("t1_end_busy", 32'(bus.busy), 32'd0);
      chk("t1_end_start", 32'(bus.tx_start), 32'd0);
      tick;
      chk("t1_no_third", 32'(bus.tx_start), 32'd0);

      // 8'hF0 with CR LF
      send_frame(8'hF0, 1'b1, 4, {8'h46, 8'h30, 8'h0D, 8'h0A}, "t2");

      // Back-to-back stream with in_valid held high
      src   = '{8'h09, 8'h9F, 8'hFF};
      exp3  = '{8'h30, 8'h39, 8'h39, 8'h46, 8'h46, 8'h46};
      got   = '{default: 8'h00};
      si    = 0;
      n_out = 0;
      cnt   = 0;
      fin   = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = src[0];
      bus.crlf_en  = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         acc = bus.in_valid && bus.in_ready;
         tick;
         bus.tx_done = 1'b0;
         if (acc) begin
            chk("t3_ready_fall", 32'(bus.in_ready), 32'd0);
            si++;
            if (si < 3) bus.in_data = src[si];
            else bus.in_valid = 1'b0;
         end
         if (bus.tx_start) begin
            if (n_out < 6) got[n_out] = bus.tx_din;
            n_out++;
            cnt = 3;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) bus.tx_done = 1'b1;
         end
         if (n_out == 6 && cnt == 0 && !bus.busy && !bus.tx_done) fin = 1'b1;
      end
      bus.in_valid = 1'b0;
      chk("t3_accepts", 32'(si), 32'd3);
      chk("t3_chars", 32'(n_out), 32'd6);
      for (int i = 0; i < 6; i++) chk("t3_char", 32'(got[i]), 32'(exp3[i]));

      // Watchdog, recovery, and set-over-clear priority
      timeout_frame(8'h55, 8'h35, "t4a");
      send_frame(8'h12, 1'b0, 2, {8'h31, 8'h32, 16'h0000}, "t4b");
      chk("t4_err_sticky", 32'(bus.err_timeout), 32'd1);
      bus.err_clr = 1'b1;
      timeout_frame(8'h55, 8'h35, "t4c");
      bus.err_clr = 1'b0;
      tick;
      chk("t4_err_held", 32'(bus.err_timeout), 32'd1);
      bus.err_clr = 1'b1;
      tick;
      bus.err_clr = 1'b0;
      chk("t4_err_clr", 32'(bus.err_timeout), 32'd0);

      // tx_done outside WAIT is ignored
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("t5_idle_busy", 32'(bus.busy), 32'd0);
      chk("t5_idle_start", 32'(bus.tx_start), 32'd0);
      tick;
      chk("t5_idle_start2", 32'(bus.tx_start), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h7E;
      tick;
      bus.in_valid = 1'b0;
      tick;
      bus.tx_done = 1'b1;
      tick;
      chk("t5_start", 32'(bus.tx_start), 32'd1);
      chk("t5_din0", 32'(bus.tx_din), 32'h37);
      tick;
      bus.tx_done = 1'b0;
      chk("t5_wait_start", 32'(bus.tx_start), 32'd0);
      tick;
      chk("t5_still_wait", 32'(bus.tx_start), 32'd0);
      chk("t5_still_din", 32'(bus.tx_din), 32'h37);
      chk("t5_still_busy", 32'(bus.busy), 32'd1);
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("t5_din1", 32'(bus.tx_din), 32'h45);
      tick;
      bus.tx_done = 1'b1;
      tick;
      bus.tx_done = 1'b0;
      chk("t5_end_busy", 32'(bus.busy), 32'd0);

      // Reset during WAIT for char1 with the buffer full
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAB;
      tick;
      bus.in_valid = 1'b0;
      tick;
      tick;
      tick;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hCD;
      bus.tx_done  = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      bus.tx_done  = 1'b0;
      chk("t6_din1", 32'(bus.tx_din), 32'h42);
      chk("t6_buf_full", 32'(bus.in_ready), 32'd0);
      tick;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(bus.in_ready), 32'd1);
      chk("t6_rst_start", 32'(bus.tx_start), 32'd0);
      chk("t6_rst_din", 32'(bus.tx_din), 32'h00);
      chk("t6_rst_busy", 32'(bus.busy), 32'd0);
      chk("t6_rst_err", 32'(bus.err_timeout), 32'd0);
      tick;
      tick;
      n_rst  = 1'b1;
      starts = 0;
      repeat (10) begin
         tick;
         starts += int'(bus.tx_start);
      end
      chk("t6_no_start", 32'(starts), 32'd0);
      chk("t6_ready", 32'(bus.in_ready), 32'd1);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      send_frame(8'hC3, 1'b0, 2, {8'h43, 8'h33, 16'h0000}, "t6b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
